// File: rtl/keypad_scan_pulse_pkg.sv
// Shared constants and code construction for the 4x4 keypad scanner.
// Code format is {1'b1, row[1:0], col[1:0]}; 5'h00 means no key.
package keypad_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    localparam logic [4:0] KEY_NONE = 5'h00;
    localparam logic [4:0] KEY_NEXT = 5'h1e;
    localparam logic [4:0] KEY_SEL  = 5'h1d;

    function automatic logic [4:0] make_code(input logic [1:0] row, input logic [1:0] col);
        return {1'b1, row, col};
    endfunction
endpackage

// File: rtl/keypad_scan_pulse_if.sv
// Keypad pin and key-code bundle between the scanner and its consumers.
interface keypad_scan_pulse_if;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [4:0] key;
    logic [4:0] key_pulse;

    modport slave  (input  key_row, output key_col, key, key_pulse);
    modport master (output key_row, input  key_col, key, key_pulse);
endinterface

// File: rtl/keypad_scan_pulse_debounce.sv
// Frame-rate debouncer: commits a code after DEBOUNCE_CNT identical frames
// and emits a single-clock pulse for each newly committed non-zero code.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_valid,
    input  logic [4:0] i_raw_code,
    output logic [4:0] o_key,
    output logic [4:0] o_key_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [4:0]    r_candidate;
    logic [CW-1:0] r_stable_cnt;
    logic [4:0]    r_key;
    logic [4:0]    r_key_pulse;

    logic          w_changed;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_commit;

    // The candidate always follows raw_code, so commit compares raw_code directly.
    always_comb begin
        w_changed = (i_raw_code != r_candidate);
        w_cnt_nxt = r_stable_cnt;
        if (w_changed)
            w_cnt_nxt = CW'(1);
        else if (r_stable_cnt < CW'(DEBOUNCE_CNT))
            w_cnt_nxt = r_stable_cnt + CW'(1);
        w_commit = i_frame_valid && (w_cnt_nxt == CW'(DEBOUNCE_CNT))
                && (w_changed || (r_stable_cnt != CW'(DEBOUNCE_CNT)))
                && (i_raw_code != r_key);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_candidate  <= KEY_NONE;
            r_stable_cnt <= '0;
            r_key        <= KEY_NONE;
            r_key_pulse  <= KEY_NONE;
        end else begin
            r_key_pulse <= KEY_NONE;
            if (i_frame_valid) begin
                r_candidate  <= i_raw_code;
                r_stable_cnt <= w_cnt_nxt;
            end
            if (w_commit) begin
                r_key <= i_raw_code;
                if (i_raw_code != KEY_NONE)
                    r_key_pulse <= i_raw_code;
            end
        end
    end

    assign o_key       = r_key;
    assign o_key_pulse = r_key_pulse;
endmodule

// File: rtl/keypad_scan_pulse.sv
// 4x4 keypad column scanner: picks the first closed switch per frame
// (lowest column, then lowest row) and hands it to the debouncer.
module keypad_scan_pulse
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    keypad_scan_pulse_if.slave  kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_col_idx;
    logic [3:0]    r_key_col;
    logic [4:0]    r_frame_code;
    logic [4:0]    r_raw_code;
    logic          r_frame_valid;

    logic          w_slot_end;
    logic          w_hit;
    logic [1:0]    w_row;
    logic [4:0]    w_sel_code;
    logic [4:0]    w_key;
    logic [4:0]    w_key_pulse;

    // Descending loop so the lowest closed row is the last assignment.
    always_comb begin
        w_slot_end = (r_div_cnt == DW'(SCAN_DIV - 1));
        w_hit      = 1'b0;
        w_row      = 2'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!kp.key_row[r]) begin
                w_hit = 1'b1;
                w_row = 2'(r);
            end
        end
        w_sel_code = r_frame_code;
        if (r_frame_code == KEY_NONE && w_hit)
            w_sel_code = make_code(w_row, r_col_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div_cnt     <= '0;
            r_col_idx     <= 2'd0;
            r_key_col     <= 4'b1110;
            r_frame_code  <= KEY_NONE;
            r_raw_code    <= KEY_NONE;
            r_frame_valid <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_slot_end) begin
                r_div_cnt <= '0;
                r_col_idx <= r_col_idx + 2'd1;
                r_key_col <= ~(4'b0001 << (r_col_idx + 2'd1));
                if (r_col_idx == 2'd3) begin
                    r_raw_code    <= w_sel_code;
                    r_frame_code  <= KEY_NONE;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_frame_code <= w_sel_code;
                end
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .i_frame_valid (r_frame_valid),
        .i_raw_code    (r_raw_code),
        .o_key         (w_key),
        .o_key_pulse   (w_key_pulse)
    );

    assign kp.key_col   = r_key_col;
    assign kp.key       = w_key;
    assign kp.key_pulse = w_key_pulse;
endmodule

// File: tb/tb_keypad_scan_pulse.sv
// Directed bench for keypad_scan_pulse with SCAN_DIV=4, DEBOUNCE_CNT=3 (16-clock frames).
module tb_keypad_scan_pulse;
    localparam int FR = 16;

    logic        clk;
    logic        rst;
    logic [15:0] press;   // bit row*4+col = switch closed
    int          checks;
    int          errors;
    int          pulse_cnt;
    logic [4:0]  last_pulse;
    logic        prev_nz;
    logic        consec;

    keypad_scan_pulse_if kp ();

    keypad_scan_pulse #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        kp.key_row = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press[r*4+c] && !kp.key_col[c])
                    kp.key_row[r] = 1'b0;
    end

    initial begin
        pulse_cnt  = 0;
        last_pulse = 5'h00;
        prev_nz    = 1'b0;
        consec     = 1'b0;
    end

    always @(negedge clk) begin
        if (kp.key_pulse != 5'h00) begin
            pulse_cnt  = pulse_cnt + 1;
            last_pulse = kp.key_pulse;
            if (prev_nz) consec = 1'b1;
        end
        prev_nz = (kp.key_pulse != 5'h00);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] bit_of(input int r, input int c);
        logic [15:0] m;
        m = 16'h0001;
        return m << (r*4 + c);
    endfunction

    initial begin
        int p0;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        press  = bit_of(3, 2);

        // Reset held with a key pressed
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_col", kp.key_col, 4'b1110);
            chk("rst_key", kp.key, 5'h00);
            chk("rst_pulse", kp.key_pulse, 5'h00);
        end
        rst   = 1'b1;
        press = '0;
        run(3);  chk("col0_hold", kp.key_col, 4'b1110);
        run(1);  chk("col1", kp.key_col, 4'b1101);
        run(4);  chk("col2", kp.key_col, 4'b1011);
        run(4);  chk("col3", kp.key_col, 4'b0111);
        run(4);  chk("col_wrap", kp.key_col, 4'b1110);
        run(FR);
        chk("post_rst_pulses", pulse_cnt, 0);
        chk("post_rst_key", kp.key, 5'h00);

        // Single press of "next"
        press = bit_of(3, 2);
        run(6*FR);
        chk("next_pulses", pulse_cnt, 1);
        chk("next_code", last_pulse, 5'h1e);
        chk("next_key", kp.key, 5'h1e);
        run(3*FR);
        chk("next_no_repeat", pulse_cnt, 1);

        // Release
        press = '0;
        run(4*FR);
        chk("release_key", kp.key, 5'h00);
        chk("release_no_pulse", pulse_cnt, 1);

        // Two keys: lowest column wins
        press = bit_of(0, 1) | bit_of(3, 2);
        run(6*FR);
        chk("multi_pulses", pulse_cnt, 2);
        chk("multi_code", last_pulse, 5'h11);
        chk("multi_key", kp.key, 5'h11);
        press = '0;
        run(6*FR);
        chk("multi_release", kp.key, 5'h00);

        // Two-frame glitch never commits
        press = bit_of(1, 1);
        for (int i = 0; i < 2*FR; i++) begin
            @(negedge clk);
            if (i % 8 == 7) chk("glitch_key", kp.key, 5'h00);
        end
        press = '0;
        run(6*FR);
        chk("glitch_pulses", pulse_cnt, 2);
        chk("glitch_key_end", kp.key, 5'h00);

        // Select, then direct switch to next, then back to select
        press = bit_of(3, 1);
        run(6*FR);
        chk("sel_pulses", pulse_cnt, 3);
        chk("sel_code", last_pulse, 5'h1d);
        chk("sel_key", kp.key, 5'h1d);
        press = bit_of(3, 2);
        run(6*FR);
        chk("sw_pulses", pulse_cnt, 4);
        chk("sw_code", last_pulse, 5'h1e);
        chk("sw_key", kp.key, 5'h1e);
        press = bit_of(3, 1);
        run(6*FR);
        chk("back_pulses", pulse_cnt, 5);
        chk("back_key", kp.key, 5'h1d);

        // Reset in the middle of debouncing "next"
        press = bit_of(3, 2);
        run(2*FR);
        chk("middeb_key", kp.key, 5'h1d);
        p0  = pulse_cnt;
        rst = 1'b0;
        run(3);
        chk("mid_rst_key", kp.key, 5'h00);
        chk("mid_rst_pulse", kp.key_pulse, 5'h00);
        chk("mid_rst_col", kp.key_col, 4'b1110);
        press = '0;
        rst   = 1'b1;
        run(3*FR);
        chk("mid_rst_no_pulse", pulse_cnt, p0);
        chk("mid_rst_key_end", kp.key, 5'h00);
        chk("no_consec_pulse", consec, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan_pulse.md
Name: keypad_scan_pulse

Overview:
- Drives a 4x4 key matrix and produces the `key` / `key_pulse` codes consumed by the menu and overlay screens.
- Scans one column at a time, picks one pressed key per scan frame, debounces across frames, and holds a stable 5-bit code.
- Emits a one-clock pulse carrying the code on each new press.
- Sits between the board keypad pins and every screen module that reads `key` / `key_pulse`.

Parameters:
- SCAN_DIV, 1000: clocks each column is held active; rows are sampled on the last clock of the slot.
- DEBOUNCE_CNT, 4: consecutive identical scan frames required before the code is committed.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising clk
- key_row  input  4  matrix rows, active-low, pulled up externally (0 = key closed on the active column)
- key_col  output  4  matrix column drive, one-hot active-low
- key  output  5  debounced held code; 5'h00 = no key
- key_pulse  output  5  code of a newly committed press for exactly one clk; 5'h00 otherwise

Behaviour:
- Code format: {1'b1, row[1:0], col[1:0]}, giving 5'h10..5'h1f. 5'h1e = row 3, col 2 ("next"). 5'h1d = row 3, col 1 ("select"). 5'h00 = none.
- Reset (rst=0 at a clock edge) forces:
  - key_col=4'b1110, col_idx=0, div_cnt=0
  - frame_code=0, raw_code=0, candidate=0, stable_cnt=0
  - key=0, key_pulse=0
  - Applies mid-scan or mid-debounce with no residual pulse afterwards.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 per column.
  - When div_cnt==SCAN_DIV-1:
    - Sample key_row into the frame accumulator.
    - col_idx wraps 3 to 0.
    - key_col <= ~(4'b0001<<next col_idx).
  - One frame is 4*SCAN_DIV clocks.
- Frame selection:
  - Within a frame, the first closed switch in scan order is kept: lowest col, then lowest row. Later hits in the same frame are ignored.
  - frame_code is cleared at frame start.
  - At the end of the col-3 slot, raw_code <= selected code (or 5'h00).
- Debounce (evaluated once per frame, the clock after raw_code updates):
  - If raw_code != candidate: candidate <= raw_code, stable_cnt <= 1.
  - Else if stable_cnt < DEBOUNCE_CNT: stable_cnt++.
  - When stable_cnt transitions to DEBOUNCE_CNT and candidate != key: key <= candidate.
  - At that same commit, if candidate != 0, key_pulse <= candidate for one clock.
  - Saturates at DEBOUNCE_CNT; a held key produces no repeat pulse.
- Release: committing 5'h00 sets key=0 with no pulse.
- Direct change A to B without an intervening release: commit B and pulse B.
- Glitch shorter than DEBOUNCE_CNT frames: key and key_pulse unchanged.
- key_pulse is never asserted on two consecutive clocks.
- DEBOUNCE_CNT=1 is legal: commit on the first frame that differs from key.
- Latency, press to pulse: at most (DEBOUNCE_CNT+1) frames + 2 clocks.

Decomposition:
- Package keypad_pkg:
  - KEY_NONE=5'h00, KEY_NEXT=5'h1e, KEY_SEL=5'h1d
  - Code-build function make_code(row, col)
  - Widths ROWS=4, COLS=4
- Sub-module key_debounce, natural split:
  - Inputs: clk, rst, frame_valid strobe, raw_code[4:0].
  - Outputs: key, key_pulse.
  - Holds the candidate/stable_cnt logic.
  - The top module keeps the scan counters and the frame accumulator.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset held low 5 clocks with row 3 pressed on col 2 → key_col=4'b1110, key=0, key_pulse=0 throughout; no pulse for at least 2 frames after release of reset.
- Row 3 closed only while col 2 is active, held 6 frames (96 clks) → exactly one key_pulse=5'h1e; key=5'h1e; no further pulses while held.
- Release after previous test → key returns to 5'h00 within 4 frames; key_pulse stays 5'h00.
- (row0,col1) and (row3,col2) pressed together → selected code 5'h11; single pulse 5'h11.
- Press present for 2 frames only, then released → key and key_pulse never leave 5'h00.
- 5'h1d held, then switched directly to 5'h1e → pulses 5'h1d then 5'h1e, each exactly one clock; rst asserted mid-debounce of 5'h1e clears all outputs with no pulse.
